// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Drives the 8-bit LED bank with one of four patterns, stepped by a
//   prescaler every DIV clock cycles. Pausing freezes both the pattern and
//   the prescaler. A mode change always re-initialises the pattern through
//   a LOAD cycle.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous active-high reset
//   mode    - pattern select: 0 COUNT, 1 SCAN, 2 BLINK, 3 FILL (pre-synchronised)
//   pause   - 1 freezes the pattern and the prescaler (synchronous)
//   leds    - registered pattern output
//   tick    - registered one-cycle pulse, high in the cycle leds steps
//   state_o - debug view of the controller: 0 LOAD, 1 RUN, 2 HOLD
module led_pattern_sequencer #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [7:0] leds,
  output logic       tick,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_COUNT = 2'd0,
    PAT_SCAN  = 2'd1,
    PAT_BLINK = 2'd2,
    PAT_FILL  = 2'd3
  } pattern_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  state_t      state;
  pattern_t    mode_q;
  dir_t        dir;
  logic [15:0] div_cnt;
  logic [7:0]  leds_init;
  logic [7:0]  leds_nxt;

  // Initial value for the pattern latched in mode_q.
  always_comb begin
    leds_init = '0;
    case (mode_q)
      PAT_COUNT: leds_init = 8'h00;
      PAT_SCAN:  leds_init = 8'h01;
      PAT_BLINK: leds_init = 8'hFF;
      PAT_FILL:  leds_init = 8'h00;
      default:   leds_init = 8'h00;
    endcase
  end

  // Next pattern value; depends only on registered state.
  always_comb begin
    leds_nxt = leds;
    case (mode_q)
      PAT_COUNT: leds_nxt = leds + 8'd1;
      PAT_SCAN:  leds_nxt = (dir == DIR_LEFT) ? (leds << 1) : (leds >> 1);
      PAT_BLINK: leds_nxt = ~leds;
      PAT_FILL:  leds_nxt = (leds == 8'hFF) ? 8'h00 : ((leds << 1) | 8'h01);
      default:   leds_nxt = leds;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds    <= '0;
      tick    <= 1'b0;
      mode_q  <= PAT_COUNT;
      div_cnt <= '0;
      dir     <= DIR_LEFT;
      state   <= LOAD;
    end else if (mode != mode_q) begin
      // Mode change beats everything, including a tick due this cycle.
      mode_q  <= pattern_t'(mode);
      state   <= LOAD;
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          leds    <= leds_init;
          dir     <= DIR_LEFT;
          div_cnt <= '0;
          tick    <= 1'b0;
          state   <= RUN;
        end
        RUN: begin
          if (pause) begin
            tick  <= 1'b0;
            state <= HOLD;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
            leds    <= leds_nxt;
            // Flip direction on landing at an end so no end value repeats.
            if (mode_q == PAT_SCAN) begin
              if (dir == DIR_LEFT && leds_nxt == 8'h80) begin
                dir <= DIR_RIGHT;
              end else if (dir == DIR_RIGHT && leds_nxt == 8'h01) begin
                dir <= DIR_LEFT;
              end
            end
          end else begin
            div_cnt <= div_cnt + 16'd1;
            tick    <= 1'b0;
          end
        end
        HOLD: begin
          tick <= 1'b0;
          if (!pause) begin
            state <= RUN;
          end
        end
        default: begin
          tick  <= 1'b0;
          state <= LOAD;
        end
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with DIV=4. Outputs are sampled
//   1 time unit after each rising clock edge; inputs change at the same point.
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] leds;
  logic       tick;
  logic [1:0] state_o;

  int tests;
  int fails;

  logic [7:0] scan_tbl [14];
  logic [7:0] fill_tbl [9];

  led_pattern_sequencer #(.DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .pause   (pause),
    .leds    (leds),
    .tick    (tick),
    .state_o (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic edge1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'd0; pause = 1'b0;
    edge1(); edge1();
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL reset_leds: got %h expected 00", leds); end
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b expected 0", tick); end
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
  endtask

  task automatic test_count;
    logic [7:0] exp_leds;
    logic       exp_tick;
    int         ticks;
    ticks = 0;
    rst = 1'b0;
    for (int c = 1; c <= 1025; c++) begin
      edge1();
      exp_leds = (c < 5) ? 8'h00 : 8'((c - 1) / 4);
      exp_tick = (c >= 5) && (((c - 1) % 4) == 0);
      if (c <= 40 && tick === 1'b1) ticks++;
      tests++; if (leds !== exp_leds) begin fails++; $display("FAIL count_leds c=%0d: got %h expected %h", c, leds, exp_leds); end
      tests++; if (tick !== exp_tick) begin fails++; $display("FAIL count_tick c=%0d: got %b expected %b", c, tick, exp_tick); end
      if (c == 1) begin
        tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL count_state_run: got %0d expected 1", state_o); end
      end
      if (c == 40) begin
        tests++; if (ticks != 9) begin fails++; $display("FAIL count_ticks40: got %0d expected 9", ticks); end
      end
    end
  endtask

  task automatic test_scan;
    logic [7:0] exp_leds;
    scan_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    mode = 2'd1;
    edge1();
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL scan_modechg_leds: got %h expected 00", leds); end
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL scan_modechg_state: got %0d expected 0", state_o); end
    edge1();
    tests++; if (leds !== 8'h01) begin fails++; $display("FAIL scan_load_leds: got %h expected 01", leds); end
    for (int k = 1; k <= 60; k++) begin
      for (int j = 1; j <= 4; j++) begin
        edge1();
        exp_leds = (j == 4) ? scan_tbl[k % 14] : scan_tbl[(k - 1) % 14];
        tests++; if (leds !== exp_leds) begin fails++; $display("FAIL scan_leds k=%0d j=%0d: got %h expected %h", k, j, leds, exp_leds); end
        tests++; if (tick !== (j == 4)) begin fails++; $display("FAIL scan_tick k=%0d j=%0d: got %b", k, j, tick); end
      end
    end
  endtask

  task automatic test_fill;
    logic [7:0] exp_leds;
    fill_tbl = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    mode = 2'd3;
    edge1();
    tests++; if (leds !== 8'h10) begin fails++; $display("FAIL fill_modechg_leds: got %h expected 10", leds); end
    edge1();
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL fill_load_leds: got %h expected 00", leds); end
    for (int k = 1; k <= 10; k++) begin
      for (int j = 1; j <= 4; j++) begin
        edge1();
        exp_leds = (j == 4) ? fill_tbl[k % 9] : fill_tbl[(k - 1) % 9];
        tests++; if (leds !== exp_leds) begin fails++; $display("FAIL fill_leds k=%0d j=%0d: got %h expected %h", k, j, leds, exp_leds); end
      end
    end
  endtask

  task automatic test_blink;
    logic [7:0] exp_leds;
    mode = 2'd2;
    edge1();
    tests++; if (leds !== 8'h01) begin fails++; $display("FAIL blink_modechg_leds: got %h expected 01", leds); end
    edge1();
    tests++; if (leds !== 8'hFF) begin fails++; $display("FAIL blink_load_leds: got %h expected ff", leds); end
    for (int k = 1; k <= 4; k++) begin
      for (int j = 1; j <= 4; j++) begin
        edge1();
        if (j == 4) exp_leds = (k % 2 == 1) ? 8'h00 : 8'hFF;
        else        exp_leds = (k % 2 == 1) ? 8'hFF : 8'h00;
        tests++; if (leds !== exp_leds) begin fails++; $display("FAIL blink_leds k=%0d j=%0d: got %h expected %h", k, j, leds, exp_leds); end
      end
    end
  endtask

  task automatic test_pause;
    mode = 2'd0;
    edge1();
    edge1();
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL pause_load_leds: got %h expected 00", leds); end
    for (int c = 1; c <= 22; c++) edge1();
    tests++; if (leds !== 8'h05) begin fails++; $display("FAIL pause_setup_leds: got %h expected 05", leds); end
    pause = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      edge1();
      tests++; if (leds !== 8'h05) begin fails++; $display("FAIL pause_hold_leds c=%0d: got %h expected 05", c, leds); end
      tests++; if (tick !== 1'b0) begin fails++; $display("FAIL pause_hold_tick c=%0d: got %b expected 0", c, tick); end
      tests++; if (state_o !== 2'd2) begin fails++; $display("FAIL pause_hold_state c=%0d: got %0d expected 2", c, state_o); end
    end
    pause = 1'b0;
    edge1();
    tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL resume_state: got %0d expected 1", state_o); end
    tests++; if (leds !== 8'h05) begin fails++; $display("FAIL resume_leds1: got %h expected 05", leds); end
    edge1();
    tests++; if (leds !== 8'h05 || tick !== 1'b0) begin fails++; $display("FAIL resume_leds2: got %h/%b expected 05/0", leds, tick); end
    edge1();
    tests++; if (leds !== 8'h06 || tick !== 1'b1) begin fails++; $display("FAIL resume_step: got %h/%b expected 06/1", leds, tick); end
  endtask

  task automatic test_hold_mode_change;
    pause = 1'b1;
    edge1();
    tests++; if (state_o !== 2'd2) begin fails++; $display("FAIL holdchg_enter: got %0d expected 2", state_o); end
    mode = 2'd2;
    edge1();
    tests++; if (state_o !== 2'd0 || leds !== 8'h06) begin fails++; $display("FAIL holdchg_load: got %0d/%h expected 0/06", state_o, leds); end
    edge1();
    tests++; if (state_o !== 2'd1 || leds !== 8'hFF) begin fails++; $display("FAIL holdchg_run: got %0d/%h expected 1/ff", state_o, leds); end
    for (int c = 1; c <= 4; c++) begin
      edge1();
      tests++; if (state_o !== 2'd2 || leds !== 8'hFF || tick !== 1'b0) begin fails++; $display("FAIL holdchg_hold c=%0d: got %0d/%h/%b expected 2/ff/0", c, state_o, leds, tick); end
    end
  endtask

  task automatic test_mode_change_tick;
    pause = 1'b0;
    mode  = 2'd0;
    edge1();
    tests++; if (leds !== 8'hFF || state_o !== 2'd0) begin fails++; $display("FAIL mct_modechg: got %h/%0d expected ff/0", leds, state_o); end
    edge1();
    tests++; if (leds !== 8'h00 || state_o !== 2'd1) begin fails++; $display("FAIL mct_load: got %h/%0d expected 00/1", leds, state_o); end
    edge1(); edge1(); edge1();
    mode = 2'd1;
    edge1();
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL mct_tick_suppressed: got %b expected 0", tick); end
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL mct_leds_old: got %h expected 00", leds); end
    edge1();
    tests++; if (leds !== 8'h01 || tick !== 1'b0) begin fails++; $display("FAIL mct_load_scan: got %h/%b expected 01/0", leds, tick); end
    for (int c = 1; c <= 3; c++) begin
      edge1();
      tests++; if (leds !== 8'h01 || tick !== 1'b0) begin fails++; $display("FAIL mct_wait c=%0d: got %h/%b expected 01/0", c, leds, tick); end
    end
    edge1();
    tests++; if (leds !== 8'h02 || tick !== 1'b1) begin fails++; $display("FAIL mct_step: got %h/%b expected 02/1", leds, tick); end
  endtask

  task automatic test_async_reset;
    for (int c = 1; c <= 16; c++) edge1();
    tests++; if (leds !== 8'h20 || tick !== 1'b1) begin fails++; $display("FAIL areset_setup: got %h/%b expected 20/1", leds, tick); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL areset_leds: got %h expected 00", leds); end
    tests++; if (tick !== 1'b0) begin fails++; $display("FAIL areset_tick: got %b expected 0", tick); end
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL areset_state: got %0d expected 0", state_o); end
    #1;
    rst = 1'b0;
    edge1();
    tests++; if (state_o !== 2'd0 || leds !== 8'h00) begin fails++; $display("FAIL areset_extra_load: got %0d/%h expected 0/00", state_o, leds); end
    edge1();
    tests++; if (state_o !== 2'd1 || leds !== 8'h01) begin fails++; $display("FAIL areset_scan_load: got %0d/%h expected 1/01", state_o, leds); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    mode  = 2'd0;
    pause = 1'b0;
    test_reset();
    test_count();
    test_scan();
    test_fill();
    test_blink();
    test_pause();
    test_hold_mode_change();
    test_mode_change_tick();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
- Controller that sequences the 8-bit LED output bank of the user module.
- Selects one of four pattern generators and paces it with an internal prescaler.
- Supports pause/resume and clean re-initialisation on mode change.
- Sits between the top-level io_in decode (clk, rst, spare mode/pause pins) and io_out[7:0].

Parameters:
- DIV, 4: clock cycles per pattern step; legal range 1..65535. The prescaler counter is fixed at 16 bits.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  pattern select: 0 COUNT, 1 SCAN, 2 BLINK, 3 FILL. Synchronous to clk; the top level provides the 2-flop synchroniser.
- pause  input  1  1 = freeze pattern and prescaler. Synchronous to clk.
- leds  output  8  registered pattern output, drives io_out[7:0].
- tick  output  1  registered one-cycle pulse, coincident with each leds step.
- state_o  output  2  debug: 0 LOAD, 1 RUN, 2 HOLD.

Behaviour:
- Reset, asynchronous: leds=0x00, tick=0, mode_q=0, div_cnt=0, dir=left, state=LOAD.
- Registered state: mode_q (2b), div_cnt (16b), dir (1b), state.
- Mode-change check, evaluated first in every state: if mode != mode_q, then mode_q<=mode, state<=LOAD, div_cnt<=0, tick<=0, leds unchanged this cycle.
- LOAD (one cycle when mode is stable):
  - leds <= init(mode_q): COUNT 0x00, SCAN 0x01, BLINK 0xFF, FILL 0x00.
  - dir<=left, div_cnt<=0, tick<=0, state<=RUN.
  - LOAD takes precedence over pause.
- RUN:
  - If pause: state<=HOLD; div_cnt, leds, dir hold; tick<=0.
  - Else if div_cnt==DIV-1: div_cnt<=0, tick<=1, leds<=next(leds).
  - Else: div_cnt<=div_cnt+1, tick<=0.
- HOLD:
  - Everything frozen, tick=0.
  - When pause=0: state<=RUN, and the count continues from the frozen div_cnt.
- Step latency: first leds step comes exactly DIV cycles after the LOAD cycle, then every DIV cycles. With DIV=1, leds steps every RUN cycle and tick stays high.
- next() rules:
  - COUNT: leds+1 mod 256; 0xFF wraps to 0x00.
  - SCAN: one-hot bounce 01,02,04..80,40..02,01,02… (period 14).
    - dir flips when the step lands on 0x80 (to right) or 0x01 (to left).
    - End values are never shown twice in a row.
  - BLINK: leds <= ~leds (0xFF <-> 0x00).
  - FILL: (leds<<1)|1 while leds != 0xFF; 0xFF -> 0x00. Sequence 00,01,03..FF,00 (period 9).
- Simultaneous events:
  - Mode change wins over a tick in the same cycle; the tick is suppressed and div_cnt is cleared.
  - A mode change while in HOLD goes to LOAD, then to RUN if pause=0 or to HOLD on the next cycle if pause=1.
- Reset mid-operation: immediate return to reset values, regardless of state; resumes via LOAD with mode_q=0, so the first LOAD after release is COUNT unless mode differs, in which case one extra LOAD cycle follows.
- leds is never combinationally dependent on inputs.

Test Plan (DIV=4):
- Reset then mode=0, pause=0 for 40 cycles -> leds 0x00 for cycles 1-4, then 0x01,0x02…; exactly 9 tick pulses, each in the same cycle as a leds increment; after 256 steps leds wraps 0xFF->0x00.
- mode=1 held for 60 steps -> leds 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02…; no repeated 0x80 or 0x01.
- mode=3 -> 00,01,03,07,0F,1F,3F,7F,FF,00,01; mode=2 -> FF,00,FF alternating every 4 cycles.
- COUNT at leds=0x05 with div_cnt=2: pause=1 for 10 cycles -> leds stays 0x05, tick=0, state_o=2; after release, 0x06 appears 2 cycles later.
- Mode 0->1 on the cycle where div_cnt==3 -> no tick that cycle and leds still old; next cycle LOAD gives leds=0x01, then 0x02 after 4 more cycles.
- Assert rst mid-SCAN at leds=0x20 -> leds=0x00 and tick=0 asynchronously, before the next clk edge; after release with mode=1 -> LOAD(COUNT), LOAD(SCAN) -> leds=0x01.
